// File: rtl/gated_rate_divider_pkg.sv
// Shared types and helpers for the gated rate divider.
package gated_rate_divider_pkg;

    localparam int unsigned RATE_SEL_W = 2;
    localparam int unsigned STATE_W    = 2;

    typedef logic [STATE_W-1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_RUN   = 2'd1;
    localparam state_t ST_DRAIN = 2'd2;

    // Half-period length in clock cycles; a zero rate yields 0 so the check trips.
    function automatic int unsigned half_len(input int unsigned clk_hz,
                                             input int unsigned rate_hz);
        if (rate_hz == 0) begin
            return 0;
        end
        return clk_hz / (2 * rate_hz);
    endfunction

endpackage

// File: rtl/gated_rate_divider_on_off_sync.sv
// Two-flop synchronizer for the asynchronous on/off request.
module on_off_sync (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    // Two-stage capture; both stages clear on reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/gated_rate_divider.sv
// Gated square-wave / tick generator with four runtime-selectable rates.
// Define GATED_RATE_DIVIDER_SYNC_EN to synchronize on_off through two flops.
module gated_rate_divider
    import gated_rate_divider_pkg::*;
#(
    parameter int unsigned CLK_HZ   = 50_000_000,
    parameter int unsigned RATE0_HZ = 1,
    parameter int unsigned RATE1_HZ = 2,
    parameter int unsigned RATE2_HZ = 5,
    parameter int unsigned RATE3_HZ = 10,
    parameter int unsigned CNT_W    = 25
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  on_off,
    input  logic [RATE_SEL_W-1:0] rate_sel,
    output logic                  wave_out,
    output logic                  tick_out,
    output logic                  running
);

    localparam int unsigned HALF0 = half_len(CLK_HZ, RATE0_HZ);
    localparam int unsigned HALF1 = half_len(CLK_HZ, RATE1_HZ);
    localparam int unsigned HALF2 = half_len(CLK_HZ, RATE2_HZ);
    localparam int unsigned HALF3 = half_len(CLK_HZ, RATE3_HZ);

    localparam longint unsigned CNT_LIM = longint'(1) << CNT_W;

    // Refuse to elaborate with a zero or over-wide half period.
    if (HALF0 < 1 || longint'(HALF0) - 1 >= CNT_LIM) begin : g_bad_half0
        $error("gated_rate_divider: HALF0 out of range");
    end
    if (HALF1 < 1 || longint'(HALF1) - 1 >= CNT_LIM) begin : g_bad_half1
        $error("gated_rate_divider: HALF1 out of range");
    end
    if (HALF2 < 1 || longint'(HALF2) - 1 >= CNT_LIM) begin : g_bad_half2
        $error("gated_rate_divider: HALF2 out of range");
    end
    if (HALF3 < 1 || longint'(HALF3) - 1 >= CNT_LIM) begin : g_bad_half3
        $error("gated_rate_divider: HALF3 out of range");
    end

    localparam logic [CNT_W-1:0] TERM0 = CNT_W'(HALF0 - 1);
    localparam logic [CNT_W-1:0] TERM1 = CNT_W'(HALF1 - 1);
    localparam logic [CNT_W-1:0] TERM2 = CNT_W'(HALF2 - 1);
    localparam logic [CNT_W-1:0] TERM3 = CNT_W'(HALF3 - 1);

    logic on_en;

`ifdef GATED_RATE_DIVIDER_SYNC_EN
    on_off_sync u_on_off_sync (
        .clock (clock),
        .reset (reset),
        .d     (on_off),
        .q     (on_en)
    );
`else
    assign on_en = on_off;
`endif

    state_t                  state, state_nx;
    logic [CNT_W-1:0]        cnt, cnt_nx;
    logic [RATE_SEL_W-1:0]   active_sel, sel_nx;
    logic                    wave_nx;
    logic                    tick_nx;
    logic [CNT_W-1:0]        term;

    // Terminal count for the rate latched at the last period start.
    always_comb begin
        term = TERM0;
        case (active_sel)
            2'd0:    term = TERM0;
            2'd1:    term = TERM1;
            2'd2:    term = TERM2;
            default: term = TERM3;
        endcase
    end

    // State register and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            active_sel <= '0;
            wave_out   <= 1'b0;
            tick_out   <= 1'b0;
            running    <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            active_sel <= sel_nx;
            wave_out   <= wave_nx;
            tick_out   <= tick_nx;
            running    <= (state_nx != ST_IDLE);
        end
    end

    // Next state, counter and waveform; a period only ends on its rising boundary.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        sel_nx   = active_sel;
        wave_nx  = wave_out;
        tick_nx  = 1'b0;

        case (state)
            ST_IDLE: begin
                wave_nx = 1'b0;
                if (on_en) begin
                    state_nx = ST_RUN;
                    wave_nx  = 1'b1;
                    tick_nx  = 1'b1;
                    cnt_nx   = '0;
                    sel_nx   = rate_sel;
                end
            end
            ST_RUN, ST_DRAIN: begin
                // Stop request / cancel never disturbs the counter or wave.
                if (state == ST_RUN && !on_en) begin
                    state_nx = ST_DRAIN;
                end else if (state == ST_DRAIN && on_en) begin
                    state_nx = ST_RUN;
                end

                if (cnt != term) begin
                    cnt_nx = cnt + CNT_W'(1);
                end else begin
                    cnt_nx = '0;
                    if (wave_out) begin
                        wave_nx = 1'b0;
                    end else if (state == ST_RUN || on_en) begin
                        wave_nx  = 1'b1;
                        tick_nx  = 1'b1;
                        sel_nx   = rate_sel;
                        state_nx = ST_RUN;
                    end else begin
                        state_nx = ST_IDLE;
                    end
                end
            end
            default: begin
                state_nx = ST_IDLE;
                cnt_nx   = '0;
                wave_nx  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_gated_rate_divider.sv
// Directed bench for gated_rate_divider at CLK_HZ=100 (HALF = 50,25,10,5).
module tb_gated_rate_divider;

`ifdef GATED_RATE_DIVIDER_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic       clock;
    logic       reset;
    logic       on_off;
    logic [1:0] rate_sel;
    logic       wave_out;
    logic       tick_out;
    logic       running;

    int tests;
    int fails;

    gated_rate_divider #(
        .CLK_HZ   (100),
        .RATE0_HZ (1),
        .RATE1_HZ (2),
        .RATE2_HZ (5),
        .RATE3_HZ (10),
        .CNT_W    (8)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .on_off   (on_off),
        .rate_sel (rate_sel),
        .wave_out (wave_out),
        .tick_out (tick_out),
        .running  (running)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input int k, input logic [2:0] exp);
        logic [2:0] obs;
        obs = {wave_out, tick_out, running};
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s k=%0d: {wave,tick,running} observed %b expected %b", tag, k, obs, exp);
        end
    endtask

    // Free-running pattern: k cycles after a rise, half-period h.
    function automatic logic [2:0] pat(input int k, input int h);
        int m;
        m = k % (2 * h);
        return {(m < h), (m == 0), 1'b1};
    endfunction

    // Reset with on_off high, release, and check the first rise.
    task automatic start(input string tag, input logic [1:0] sel, input int rst_cycles);
        reset    = 1'b1;
        on_off   = 1'b1;
        rate_sel = sel;
        for (int i = 0; i < rst_cycles; i++) begin
            step();
            check({tag, "_rst"}, i, 3'b000);
        end
        reset = 1'b0;
        for (int i = 0; i < LAT; i++) begin
            step();
            check({tag, "_lat"}, i, 3'b000);
        end
        step();
        check({tag, "_rise"}, 0, 3'b111);
    endtask

    initial begin
        logic [2:0] e;
        tests    = 0;
        fails    = 0;
        reset    = 1'b1;
        on_off   = 1'b0;
        rate_sel = 2'd0;

        // Reset held 3 cycles with on_off high, then rate 3 free-running.
        start("t1", 2'd3, 3);
        for (int k = 1; k < 30; k++) begin
            step();
            check("t1_run", k, pat(k, 5));
        end

        // Rate change mid-period applies at the next rising boundary.
        start("t2", 2'd3, 1);
        for (int k = 1; k < 50; k++) begin
            step();
            e = (k < 10) ? pat(k, 5) : pat(k - 10, 10);
            check("t2_sel", k, e);
            if (k == 2) rate_sel = 2'd2;
        end

        // Stop request: period completes, then idle with running low.
        start("t3", 2'd3, 1);
        for (int k = 1; k < 20; k++) begin
            step();
            if (k < 5)       e = 3'b101;
            else if (k < 10) e = 3'b001;
            else             e = 3'b000;
            check("t3_drain", k, e);
            if (k == 2) on_off = 1'b0;
        end

        // Stop then cancel within the period: waveform uninterrupted.
        start("t4", 2'd3, 1);
        for (int k = 1; k < 30; k++) begin
            step();
            check("t4_cancel", k, pat(k, 5));
            if (k == 2) on_off = 1'b0;
            if (k == 7) on_off = 1'b1;
        end

        // Slowest rate: 50-cycle phases across two full periods.
        start("t5", 2'd0, 1);
        for (int k = 1; k < 110; k++) begin
            step();
            check("t5_slow", k, pat(k, 50));
        end

        // Reset mid high phase forces idle; rise follows release.
        start("t6", 2'd3, 1);
        for (int k = 1; k < 3; k++) begin
            step();
            check("t6_pre", k, pat(k, 5));
        end
        reset = 1'b1;
        step();
        check("t6_rst", 3, 3'b000);
        reset = 1'b0;
        for (int i = 0; i < LAT; i++) begin
            step();
            check("t6_lat", i, 3'b000);
        end
        step();
        check("t6_rise", 0, 3'b111);
        for (int k = 1; k < 12; k++) begin
            step();
            check("t6_run", k, pat(k, 5));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
